// File: rtl/io_wait_ctrl.sv
// io_wait_ctrl: inserts CPU /WAIT states for I/O cycles that hit a mapped
// tile window, releasing on tile ready, on a ready-timeout, or when the CPU
// abandons the cycle. Unmapped cycles are flagged with a one-clock strobe.
module io_wait_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorq_n,
  input  logic       is_read,
  input  logic       is_write,
  input  logic       win_valid,
  input  logic [2:0] win_idx,
  input  logic       tile_rdy_n,
  input  logic [3:0] cfg_min_wait,
  input  logic [7:0] cfg_timeout,
  input  logic       to_clr,
  output logic       wait_n,
  output logic       cycle_act,
  output logic       unmapped_stb,
  output logic       to_stb,
  output logic       to_flag,
  output logic [2:0] to_idx
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MIN = 3'd1,
    WAIT_RDY = 3'd2,
    HOLD     = 3'd3,
    TIMEOUT  = 3'd4
  } state_t;

  state_t     state, state_nx;

  logic       iorq_m, iorq_s;
  logic       rdy_m, rdy_s;

  logic [3:0] mcnt, mcnt_nx;
  logic [7:0] tcnt, tcnt_nx;
  logic [2:0] idx_q, idx_nx;

  logic       wait_nx, act_nx, unm_nx, tos_nx, flag_nx;
  logic [2:0] to_idx_nx;

  logic       start_map;
  logic       to_hit;

  assign start_map = win_valid & (is_read | is_write);
  // Widened compare so a saturated tcnt (255) can never match an 8-bit limit.
  assign to_hit    = (cfg_timeout != 8'd0) &&
                     (({1'b0, tcnt} + 9'd1) == {1'b0, cfg_timeout});

  // Two-flop synchronizers for the asynchronous CPU and tile handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      iorq_m <= 1'b1;
      iorq_s <= 1'b1;
      rdy_m  <= 1'b1;
      rdy_s  <= 1'b1;
    end else begin
      iorq_m <= iorq_n;
      iorq_s <= iorq_m;
      rdy_m  <= tile_rdy_n;
      rdy_s  <= rdy_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a CPU abort outranks every other exit from the wait
  // states, and ready outranks the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!iorq_s) begin
          if (start_map) state_nx = (cfg_min_wait == 4'd0) ? WAIT_RDY : WAIT_MIN;
          else           state_nx = HOLD;
        end
      end
      WAIT_MIN: begin
        if (iorq_s)            state_nx = IDLE;
        else if (mcnt <= 4'd1) state_nx = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (iorq_s)      state_nx = IDLE;
        else if (!rdy_s) state_nx = HOLD;
        else if (to_hit) state_nx = TIMEOUT;
      end
      HOLD, TIMEOUT: begin
        if (iorq_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and cycle counters, derived from
  // the current state and the transition being taken.
  always_comb begin
    mcnt_nx   = mcnt;
    tcnt_nx   = tcnt;
    idx_nx    = idx_q;
    to_idx_nx = to_idx;
    unm_nx    = 1'b0;
    tos_nx    = 1'b0;
    flag_nx   = to_flag & ~to_clr;
    wait_nx   = !((state_nx == WAIT_MIN) || (state_nx == WAIT_RDY));
    act_nx    = (state_nx != IDLE);
    case (state)
      IDLE: begin
        if (state_nx == HOLD) begin
          unm_nx = 1'b1;
        end else if (state_nx != IDLE) begin
          idx_nx  = win_idx;
          mcnt_nx = cfg_min_wait;
          tcnt_nx = '0;
        end
      end
      WAIT_MIN: begin
        if (!iorq_s) begin
          if (mcnt != 4'd0) mcnt_nx = mcnt - 4'd1;
          if (state_nx == WAIT_RDY) tcnt_nx = '0;
        end
      end
      WAIT_RDY: begin
        if (!iorq_s && rdy_s) begin
          if (tcnt != 8'hFF) tcnt_nx = tcnt + 8'd1;
        end
        if (state_nx == TIMEOUT) begin
          tos_nx    = 1'b1;
          flag_nx   = 1'b1;
          to_idx_nx = idx_q;
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_n       <= 1'b1;
      cycle_act    <= 1'b0;
      unmapped_stb <= 1'b0;
      to_stb       <= 1'b0;
      to_flag      <= 1'b0;
      to_idx       <= '0;
      mcnt         <= '0;
      tcnt         <= '0;
      idx_q        <= '0;
    end else begin
      wait_n       <= wait_nx;
      cycle_act    <= act_nx;
      unmapped_stb <= unm_nx;
      to_stb       <= tos_nx;
      to_flag      <= flag_nx;
      to_idx       <= to_idx_nx;
      mcnt         <= mcnt_nx;
      tcnt         <= tcnt_nx;
      idx_q        <= idx_nx;
    end
  end

endmodule

// File: tb/tb_io_wait_ctrl.sv
// Testbench for io_wait_ctrl: directed scenarios plus a randomized run, all
// compared against a cycle-level behavioural model of the I/O wait protocol.
module tb_io_wait_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iorq_n = 1'b1;
  logic       is_read = 1'b0;
  logic       is_write = 1'b0;
  logic       win_valid = 1'b0;
  logic [2:0] win_idx = '0;
  logic       tile_rdy_n = 1'b1;
  logic [3:0] cfg_min_wait = '0;
  logic [7:0] cfg_timeout = '0;
  logic       to_clr = 1'b0;
  logic       wait_n, cycle_act, unmapped_stb, to_stb, to_flag;
  logic [2:0] to_idx;

  int checks = 0;
  int errors = 0;

  io_wait_ctrl dut (
    .clk(clk), .rst(rst), .iorq_n(iorq_n), .is_read(is_read), .is_write(is_write),
    .win_valid(win_valid), .win_idx(win_idx), .tile_rdy_n(tile_rdy_n),
    .cfg_min_wait(cfg_min_wait), .cfg_timeout(cfg_timeout), .to_clr(to_clr),
    .wait_n(wait_n), .cycle_act(cycle_act), .unmapped_stb(unmapped_stb),
    .to_stb(to_stb), .to_flag(to_flag), .to_idx(to_idx)
  );

  always #5 clk = ~clk;

  // Behavioural model: a cycle is idle, busy (CPU held in wait) or parked
  // (waiting for the CPU to end the cycle). Busy time is tracked as clocks
  // elapsed in the minimum-wait phase and clocks spent waiting for ready.
  typedef enum {M_IDLE, M_BUSY, M_PARK} mode_t;
  mode_t      mode = M_IDLE;
  logic [1:0] isync = 2'b11, rsync = 2'b11;
  int         elapsed = 0, rwait = 0, lat_min = 0;
  logic [2:0] lat_idx = '0;
  logic       e_unm = 0, e_tos = 0, e_flag = 0;
  logic [2:0] e_idx = '0;

  always @(posedge clk) begin
    logic oi, orr, timed;
    if (rst) begin
      isync = 2'b11; rsync = 2'b11; mode = M_IDLE;
      e_unm = 0; e_tos = 0; e_flag = 0; e_idx = '0;
    end else begin
      oi = isync[1]; orr = rsync[1];
      isync = {isync[0], iorq_n};
      rsync = {rsync[0], tile_rdy_n};
      e_unm = 0; e_tos = 0; timed = 0;
      case (mode)
        M_IDLE: if (!oi) begin
          if (win_valid && (is_read || is_write)) begin
            mode = M_BUSY; lat_min = cfg_min_wait; lat_idx = win_idx;
            elapsed = 0; rwait = 0;
          end else begin
            mode = M_PARK; e_unm = 1;
          end
        end
        M_BUSY: begin
          if (oi) mode = M_IDLE;
          else if (elapsed < lat_min) elapsed++;
          else if (!orr) mode = M_PARK;
          else if (cfg_timeout != 0 && rwait + 1 == int'(cfg_timeout)) begin
            mode = M_PARK; timed = 1;
          end else if (rwait < 255) rwait++;
        end
        default: if (oi) mode = M_IDLE;
      endcase
      if (timed) begin
        e_tos = 1; e_flag = 1; e_idx = lat_idx;
      end else if (to_clr) e_flag = 0;
    end
  end

  function automatic logic [7:0] exp_o();
    return {(mode != M_BUSY), (mode != M_IDLE), e_unm, e_tos, e_flag, e_idx};
  endfunction

  logic [7:0] dut_o;
  assign dut_o = {wait_n, cycle_act, unmapped_stb, to_stb, to_flag, to_idx};

  task automatic test_reset();
    rst = 1'b1; iorq_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_o !== 8'h80) begin
      errors++; $display("FAIL reset_state dut=%b want=%b", dut_o, 8'h80);
    end
    rst = 1'b0; iorq_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL reset_idle k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
    end
  endtask

  task automatic test_mapped();
    cfg_min_wait = 4'd3; cfg_timeout = 8'd0; win_valid = 1; is_read = 1; is_write = 0;
    win_idx = 3'($urandom_range(0, 7)); tile_rdy_n = 1; iorq_n = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL mapped_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      checks++;
      if (wait_n !== ((k >= 3 && k <= 14) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL mapped_wait k=%0d wait_n=%b", k, wait_n);
      end
      checks++;
      if (unmapped_stb !== 1'b0 || to_stb !== 1'b0) begin
        errors++; $display("FAIL mapped_strobes k=%0d unm=%b to=%b want 0 0", k, unmapped_stb, to_stb);
      end
      // ready drop timed so the CPU is held for clocks 3..14
      if (k == 12) tile_rdy_n = 0;
      if (k == 17) begin iorq_n = 1; tile_rdy_n = 1; end
    end
  endtask

  task automatic test_unmapped();
    win_valid = 0; is_read = 1; is_write = 0; iorq_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL unmapped_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      checks++;
      if (unmapped_stb !== (k == 3) || wait_n !== 1'b1) begin
        errors++; $display("FAIL unmapped_pulse k=%0d unm=%b wait_n=%b", k, unmapped_stb, wait_n);
      end
      if (k == 8 || k == 9) begin
        checks++;
        if (cycle_act !== (k == 8)) begin
          errors++; $display("FAIL unmapped_return k=%0d act=%b want=%b", k, cycle_act, k == 8);
        end
      end
      if (k == 6) iorq_n = 1;
    end
  endtask

  task automatic test_timeout();
    cfg_min_wait = 0; cfg_timeout = 8'd20; win_valid = 1; is_read = 1; win_idx = 3'd5;
    tile_rdy_n = 1; iorq_n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL timeout_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      checks++;
      if (to_stb !== (k == 23)) begin
        errors++; $display("FAIL timeout_stb k=%0d to_stb=%b", k, to_stb);
      end
      if (k == 22 || k == 23) begin
        checks++;
        if (wait_n !== (k == 23)) begin
          errors++; $display("FAIL timeout_wait k=%0d wait_n=%b", k, wait_n);
        end
      end
      if (k == 23) begin
        checks++;
        if (to_flag !== 1'b1 || to_idx !== 3'd5) begin
          errors++; $display("FAIL timeout_flag flag=%b idx=%0d want 1 5", to_flag, to_idx);
        end
      end
      if (k == 25) iorq_n = 1;
    end
    // second timeout with to_clr landing in the same clock
    cfg_timeout = 8'd4; iorq_n = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL timeout2_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      if (k == 7) begin
        checks++;
        if (to_stb !== 1'b1 || to_flag !== 1'b1) begin
          errors++; $display("FAIL timeout2_setwins to_stb=%b flag=%b want 1 1", to_stb, to_flag);
        end
      end
      to_clr = (k == 6 || k == 12);
      if (k == 9) iorq_n = 1;
    end
    checks++;
    if (to_flag !== 1'b0) begin
      errors++; $display("FAIL timeout_clear flag=%b want 0", to_flag);
    end
  endtask

  task automatic test_abort();
    cfg_min_wait = 4'd15; cfg_timeout = 0; win_valid = 1; is_read = 0; is_write = 1;
    tile_rdy_n = 1; iorq_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL abort_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      checks++;
      if (unmapped_stb !== 1'b0 || to_stb !== 1'b0) begin
        errors++; $display("FAIL abort_strobes k=%0d unm=%b to=%b", k, unmapped_stb, to_stb);
      end
      if (k == 7 || k == 8) begin
        checks++;
        if (wait_n !== (k == 8) || cycle_act !== (k == 7)) begin
          errors++; $display("FAIL abort_release k=%0d wait_n=%b act=%b", k, wait_n, cycle_act);
        end
      end
      if (k == 5) iorq_n = 1;
    end
    // following cycle: min 2, tile already ready
    cfg_min_wait = 4'd2; tile_rdy_n = 0; iorq_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL abort_next_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      checks++;
      if (wait_n !== ((k >= 3 && k <= 5) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL abort_next_wait k=%0d wait_n=%b", k, wait_n);
      end
      if (k == 8) iorq_n = 1;
    end
    tile_rdy_n = 1;
  endtask

  task automatic test_reset_mid();
    cfg_min_wait = 0; cfg_timeout = 0; win_valid = 1; is_read = 1; is_write = 0;
    tile_rdy_n = 1; iorq_n = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL rstmid_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      if (k == 7 || k == 9 || k == 10) begin
        checks++;
        if (wait_n !== (k != 10)) begin
          errors++; $display("FAIL rstmid_wait k=%0d wait_n=%b", k, wait_n);
        end
      end
      rst = (k == 6);
      if (k == 12) iorq_n = 1;
    end
  endtask

  task automatic test_rdy_vs_timeout();
    cfg_min_wait = 0; cfg_timeout = 8'd4; win_valid = 1; is_read = 1;
    tile_rdy_n = 1; iorq_n = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL rdyto_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      if (k == 7) begin
        checks++;
        if (to_stb !== 1'b0 || wait_n !== 1'b1 || cycle_act !== 1'b1) begin
          errors++; $display("FAIL rdyto_hold to_stb=%b wait_n=%b act=%b want 0 1 1", to_stb, wait_n, cycle_act);
        end
      end
      if (k == 4) tile_rdy_n = 0;
      if (k == 9) iorq_n = 1;
    end
    tile_rdy_n = 1;
  endtask

  task automatic test_random();
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      checks++;
      if (dut_o !== exp_o()) begin
        errors++; $display("FAIL random_model k=%0d dut=%b model=%b", k, dut_o, exp_o());
      end
      if ($urandom_range(0, 11) == 0) iorq_n = ~iorq_n;
      if ($urandom_range(0, 7) == 0) tile_rdy_n = ~tile_rdy_n;
      win_valid    = ($urandom_range(0, 4) != 0);
      is_read      = 1'($urandom_range(0, 1));
      is_write     = 1'($urandom_range(0, 1));
      win_idx      = 3'($urandom_range(0, 7));
      cfg_min_wait = 4'($urandom_range(0, 4));
      cfg_timeout  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      to_clr       = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 199) == 0);
    end
    rst = 0; to_clr = 0;
  endtask

  initial begin
    test_reset();
    test_mapped();
    test_unmapped();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_rdy_vs_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
